multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: INSTRET_W, 32, width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 Instr  in  32  instruction register contents; uses op[6:0], funct3[14:12], funct7b5[30].
REQ-005 Zero  in  1  ALU zero flag from the datapath.
REQ-006 mem_ready  in  1  memory completes the current access this cycle.
REQ-007 mem_req  out  1  memory access request, held until mem_ready.
REQ-008 MemWrite  out  1  current request is a store.
REQ-009 AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 IRWrite  out  1  load Instr and OldPC.
REQ-011 PCWrite  out  1  load PC from Result.
REQ-012 RegWrite  out  1  register file write enable.
REQ-013 ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
REQ-014 ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1.
REQ-015 ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=constant 4.
REQ-016 ImmSrc  out  3  000=I, 001=S, 010=B, 011=J.
REQ-017 ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU.
REQ-018 illegal  out  1  sticky: unsupported opcode/funct decoded.
REQ-019 instret  out  INSTRET_W  count of retired instructions.

Function
REQ-020 FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, ILLEGAL.
REQ-021 FETCH: mem_req=1, AdrSrc=0; on mem_ready: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10, ->DECODE; else stay, IRWrite=PCWrite=0.
REQ-022 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=010, ADD (computes branch target); next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, other->ILLEGAL.
REQ-023 MEMADR: ALUSrcA=10, ALUSrcB=01, ADD, ImmSrc=000 for load (->MEMREAD) or 001 for store (->MEMWRITE).
REQ-024 MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00; on mem_ready ->MEMWB.
REQ-025 MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00; on mem_ready retire ->FETCH.
REQ-026 MEMWB: ResultSrc=01, RegWrite=1, retire ->FETCH.
REQ-027 EXECR: ALUSrcA=10, ALUSrcB=00, ALU op from funct3/funct7b5 (000 ADD/SUB by funct7b5) ->ALUWB.
REQ-028 EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALU op from funct3; funct7b5 selects SUB never, SRA only for funct3=101 ->ALUWB.
REQ-029 ALUWB: ResultSrc=00, RegWrite=1, retire ->FETCH.
REQ-030 BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00; PCWrite = Zero XNOR funct3[0] complement (beq taken on Zero=1, bne on Zero=0); funct3 not 000/001 ->ILLEGAL; else retire ->FETCH.
REQ-031 JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1, RegWrite held to next cycle via ALUWB path (rd=OldPC+4 written in ALUWB); ->ALUWB, no double retire.
REQ-032 ILLEGAL: all enables 0, mem_req=0, illegal=1; remain until reset.
REQ-033 Undefined funct3/funct7 in EXECR ->ILLEGAL instead of ALUWB.
REQ-034 All outputs not listed for a state are 0; outputs are Moore except FETCH/BRANCH enables gated by mem_ready/Zero.
REQ-035 instret increments by 1 on each retire cycle; wraps modulo 2^INSTRET_W.
REQ-036 mem_req, MemWrite, AdrSrc stable while waiting for mem_ready; no cycle limit.

Reset
REQ-037 reset=0 asynchronously forces state=FETCH, illegal=0, instret=0; all enables 0 while asserted.
REQ-038 Reset during MEMREAD/MEMWRITE drops mem_req immediately; no register or PC write occurs.
REQ-039 First mem_req asserts in the first cycle after reset deasserts.

Structure
REQ-040 Package ctrl_pkg: state enum, ALUControl encodings, ImmSrc encodings, opcode constants.
REQ-041 Sub-module alu_decoder (combinational: aluop class, funct3, funct7b5, op[5] -> ALUControl, illegal flag).

Verification
REQ-042 Reset, mem_ready=1: FETCH IRWrite+PCWrite cycle 1, DECODE cycle 2.
REQ-043 lw x5,8(x1) with mem_ready delayed 2 cycles each access: 8 cycles to retire, instret=1, RegWrite only in MEMWB.
REQ-044 beq Zero=1 -> PCWrite=1 in BRANCH; bne Zero=1 -> PCWrite=0; both retire.
REQ-045 op=1111111 -> ILLEGAL after DECODE, illegal=1, mem_req=0 for 20 cycles.
REQ-046 reset=0 mid-MEMWRITE -> mem_req, MemWrite 0 same cycle, instret=0, restart in FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control unit.
package ctrl_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OP_W    = 7;

   // Opcodes handled by the controller
   localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_ILLEGAL
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_SLL  = 4'b0110,
      ALU_SRL  = 4'b0111,
      ALU_SRA  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_DATA      = 2'b01,
      RES_ALURESULT = 2'b10
   } res_src_t;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'b00,
      SRCA_OLDPC = 2'b01,
      SRCA_RS1   = 2'b10
   } src_a_t;

   typedef enum logic [1:0] {
      SRCB_RS2  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } src_b_t;

   // ALU operation class requested by the main FSM
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU command decode from operation class and instruction function fields.
module alu_decoder
   import ctrl_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output alu_ctrl_t  alu_ctrl,
   output logic       illegal
);

   // Pick the ALU command; op5 separates register forms from immediate forms.
   always_comb begin
      alu_ctrl = ALU_ADD;
      illegal  = 1'b0;
      case (aluop)
         ALUOP_ADD: alu_ctrl = ALU_ADD;
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         default: begin
            case (funct3)
               3'b000: begin
                  // Immediate bit 30 must not turn addi into a subtract
                  if (op5 && funct7b5) alu_ctrl = ALU_SUB;
                  else                 alu_ctrl = ALU_ADD;
               end
               3'b001: alu_ctrl = ALU_SLL;
               3'b010: alu_ctrl = ALU_SLT;
               3'b011: alu_ctrl = ALU_SLTU;
               3'b100: alu_ctrl = ALU_XOR;
               3'b101: begin
                  if (funct7b5) alu_ctrl = ALU_SRA;
                  else          alu_ctrl = ALU_SRL;
               end
               3'b110: alu_ctrl = ALU_OR;
               default: alu_ctrl = ALU_AND;
            endcase
            // Register forms only define funct7b5 for ADD/SUB and SRL/SRA
            illegal = op5 && funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101);
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 controller: main FSM, ALU decode and retired-instruction count.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [INSTR_W-1:0]   Instr,
   input  logic                 Zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 MemWrite,
   output logic                 AdrSrc,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 RegWrite,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [2:0]           ImmSrc,
   output logic [3:0]           ALUControl,
   output logic                 illegal,
   output logic [INSTRET_W-1:0] instret
);

   state_t                state_q, state_d;
   logic [INSTRET_W-1:0]  instret_q;

   logic [OP_W-1:0] op;
   logic [2:0]      funct3;
   logic            funct7b5;
   logic            unused_instr_bits;

   logic      mem_req_s, memwrite_s, adrsrc_s, irwrite_s, pcwrite_s, regwrite_s;
   res_src_t  resultsrc_s;
   src_a_t    srca_s;
   src_b_t    srcb_s;
   imm_src_t  immsrc_s;
   aluop_t    aluop;
   alu_ctrl_t alu_ctrl;
   logic      dec_illegal;
   logic      retire;

   assign op       = Instr[6:0];
   assign funct3   = Instr[14:12];
   assign funct7b5 = Instr[30];
   // Register/immediate fields belong to the datapath
   assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

   alu_decoder u_alu_decoder (
      .aluop    (aluop),
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .op5      (op[5]),
      .alu_ctrl (alu_ctrl),
      .illegal  (dec_illegal)
   );

   // State register; reset returns the controller to instruction fetch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Retired-instruction counter, wrapping at its width.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      instret_q <= '0;
      else if (retire) instret_q <= instret_q + INSTRET_W'(1);
   end

   // Next state and per-state controls; only FETCH and BRANCH enables look at inputs.
   always_comb begin
      state_d     = state_q;
      mem_req_s   = 1'b0;
      memwrite_s  = 1'b0;
      adrsrc_s    = 1'b0;
      irwrite_s   = 1'b0;
      pcwrite_s   = 1'b0;
      regwrite_s  = 1'b0;
      resultsrc_s = RES_ALUOUT;
      srca_s      = SRCA_PC;
      srcb_s      = SRCB_RS2;
      immsrc_s    = IMM_I;
      aluop       = ALUOP_ADD;
      retire      = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_s   = 1'b1;
            srcb_s      = SRCB_FOUR;
            resultsrc_s = RES_ALURESULT;
            if (mem_ready) begin
               irwrite_s = 1'b1;
               pcwrite_s = 1'b1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            // ALU forms the branch target from OldPC + B-immediate
            srca_s   = SRCA_OLDPC;
            srcb_s   = SRCB_IMM;
            immsrc_s = IMM_B;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               default:           state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            srca_s = SRCA_RS1;
            srcb_s = SRCB_IMM;
            // op[5] is the only bit separating store from load
            if (op[5]) begin
               immsrc_s = IMM_S;
               state_d  = S_MEMWRITE;
            end else begin
               immsrc_s = IMM_I;
               state_d  = S_MEMREAD;
            end
         end
         S_MEMREAD: begin
            mem_req_s = 1'b1;
            adrsrc_s  = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWRITE: begin
            mem_req_s  = 1'b1;
            memwrite_s = 1'b1;
            adrsrc_s   = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEMWB: begin
            resultsrc_s = RES_DATA;
            regwrite_s  = 1'b1;
            retire      = 1'b1;
            state_d     = S_FETCH;
         end
         S_EXECR: begin
            srca_s = SRCA_RS1;
            srcb_s = SRCB_RS2;
            aluop  = ALUOP_FUNCT;
            if (dec_illegal) state_d = S_ILLEGAL;
            else             state_d = S_ALUWB;
         end
         S_EXECI: begin
            srca_s   = SRCA_RS1;
            srcb_s   = SRCB_IMM;
            immsrc_s = IMM_I;
            aluop    = ALUOP_FUNCT;
            state_d  = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite_s = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            srca_s = SRCA_RS1;
            srcb_s = SRCB_RS2;
            aluop  = ALUOP_SUB;
            if (funct3[2:1] == 2'b00) begin
               // beq takes on Zero, bne on !Zero
               pcwrite_s = Zero ^ funct3[0];
               retire    = 1'b1;
               state_d   = S_FETCH;
            end else begin
               state_d   = S_ILLEGAL;
            end
         end
         S_JAL: begin
            // Link value OldPC+4 is written back from ALUOut in ALUWB
            srca_s    = SRCA_OLDPC;
            srcb_s    = SRCB_FOUR;
            pcwrite_s = 1'b1;
            state_d   = S_ALUWB;
         end
         S_ILLEGAL: state_d = S_ILLEGAL;
         default:   state_d = S_FETCH;
      endcase
   end

   // Reset forces every control low immediately, including an in-flight mem_req.
   assign mem_req    = reset & mem_req_s;
   assign MemWrite   = reset & memwrite_s;
   assign AdrSrc     = reset & adrsrc_s;
   assign IRWrite    = reset & irwrite_s;
   assign PCWrite    = reset & pcwrite_s;
   assign RegWrite   = reset & regwrite_s;
   assign ResultSrc  = reset ? resultsrc_s : 2'b00;
   assign ALUSrcA    = reset ? srca_s      : 2'b00;
   assign ALUSrcB    = reset ? srcb_s      : 2'b00;
   assign ImmSrc     = reset ? immsrc_s    : 3'b000;
   assign ALUControl = reset ? alu_ctrl    : 4'b0000;
   assign illegal    = reset & (state_q == S_ILLEGAL);
   assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle control vectors via a scoreboard queue.
module tb_multicycle_ctrl;

   localparam int unsigned INSTRET_W = 32;

   localparam logic [31:0] I_ADDI   = 32'h00500093; // addi x1,x0,5
   localparam logic [31:0] I_ADDI30 = 32'h40000093; // addi x1,x0,0x400 (bit30 set)
   localparam logic [31:0] I_SUB    = 32'h402081B3;
   localparam logic [31:0] I_SRA    = 32'h4020D1B3;
   localparam logic [31:0] I_SRAI   = 32'h4020D193;
   localparam logic [31:0] I_SLTIU  = 32'h0010B193;
   localparam logic [31:0] I_AND    = 32'h0020F1B3;
   localparam logic [31:0] I_SLT    = 32'h0020A1B3;
   localparam logic [31:0] I_XORI   = 32'h0010C193;
   localparam logic [31:0] I_RBAD   = 32'h402091B3; // funct3=001 with funct7b5
   localparam logic [31:0] I_LW     = 32'h0080A283; // lw x5,8(x1)
   localparam logic [31:0] I_SW     = 32'h0020A223; // sw x2,4(x1)
   localparam logic [31:0] I_BEQ    = 32'h00208463;
   localparam logic [31:0] I_BNE    = 32'h00209463;
   localparam logic [31:0] I_BBAD   = 32'h0020A463; // funct3=010 branch
   localparam logic [31:0] I_JAL    = 32'h008000EF;
   localparam logic [31:0] I_OPBAD  = 32'h0000007F;

   logic                 clk, reset, Zero, mem_ready;
   logic [31:0]          Instr;
   logic                 mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
   logic [1:0]           ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0]           ImmSrc;
   logic [3:0]           ALUControl;
   logic [INSTRET_W-1:0] instret;

   multicycle_ctrl #(.INSTRET_W(INSTRET_W)) dut (
      .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal),
      .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite;
      logic [1:0] resultsrc, srca, srcb;
      logic [2:0] immsrc;
      logic [3:0] alu;
      logic       ill;
   } ctl_t;

   typedef struct packed {
      logic [31:0]          ir;
      logic                 rdy;
      logic                 z;
      ctl_t                 ctl;
      logic [INSTRET_W-1:0] icnt;
   } sb_t;

   sb_t                  sb[$];
   int unsigned          n_checks = 0;
   int unsigned          n_pass   = 0;
   logic [INSTRET_W-1:0] exp_instret = '0;

   // Expected control vectors, one per FSM state
   function automatic ctl_t c_fetch(input logic rdy);
      ctl_t c = '0;
      c.mem_req = 1'b1; c.irwrite = rdy; c.pcwrite = rdy;
      c.srcb = 2'b10; c.resultsrc = 2'b10;
      return c;
   endfunction
   function automatic ctl_t c_decode();
      ctl_t c = '0;
      c.srca = 2'b01; c.srcb = 2'b01; c.immsrc = 3'b010;
      return c;
   endfunction
   function automatic ctl_t c_memadr(input logic st);
      ctl_t c = '0;
      c.srca = 2'b10; c.srcb = 2'b01; c.immsrc = st ? 3'b001 : 3'b000;
      return c;
   endfunction
   function automatic ctl_t c_mem(input logic st);
      ctl_t c = '0;
      c.mem_req = 1'b1; c.adrsrc = 1'b1; c.memwrite = st;
      return c;
   endfunction
   function automatic ctl_t c_memwb();
      ctl_t c = '0;
      c.resultsrc = 2'b01; c.regwrite = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_exec(input logic isr, input logic [3:0] alu);
      ctl_t c = '0;
      c.srca = 2'b10; c.srcb = isr ? 2'b00 : 2'b01; c.alu = alu;
      return c;
   endfunction
   function automatic ctl_t c_aluwb();
      ctl_t c = '0;
      c.regwrite = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_branch(input logic pcw);
      ctl_t c = '0;
      c.srca = 2'b10; c.alu = 4'b0001; c.pcwrite = pcw;
      return c;
   endfunction
   function automatic ctl_t c_jal();
      ctl_t c = '0;
      c.srca = 2'b01; c.srcb = 2'b10; c.pcwrite = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_illegal();
      ctl_t c = '0;
      c.ill = 1'b1;
      return c;
   endfunction

   function automatic ctl_t observe();
      ctl_t c;
      c.mem_req = mem_req;   c.memwrite = MemWrite; c.adrsrc = AdrSrc;
      c.irwrite = IRWrite;   c.pcwrite = PCWrite;   c.regwrite = RegWrite;
      c.resultsrc = ResultSrc; c.srca = ALUSrcA;    c.srcb = ALUSrcB;
      c.immsrc = ImmSrc;     c.alu = ALUControl;    c.ill = illegal;
      return c;
   endfunction

   task automatic push(input logic [31:0] ir, input logic rdy, input logic z, input ctl_t c);
      sb_t e;
      e.ir = ir; e.rdy = rdy; e.z = z; e.ctl = c; e.icnt = exp_instret;
      sb.push_back(e);
   endtask

   task automatic push_alu(input logic [31:0] ir, input logic isr, input logic [3:0] alu);
      push(ir, 1'b1, 1'b0, c_fetch(1'b1));
      push(ir, 1'b0, 1'b0, c_decode());
      push(ir, 1'b0, 1'b0, c_exec(isr, alu));
      push(ir, 1'b0, 1'b0, c_aluwb());
      exp_instret++;
   endtask

   task automatic test_reset();
      sb_t e;
      reset = 1'b0; Zero = 1'b1; mem_ready = 1'b1; Instr = I_JAL;
      repeat (2) @(posedge clk);
      #1;
      push(I_JAL, 1'b1, 1'b1, '0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         Instr = e.ir; mem_ready = e.rdy; Zero = e.z;
         @(negedge clk);
         n_checks++;
         if ({observe(), instret} !== {e.ctl, e.icnt})
            $display("FAIL reset: got ctl=%h instret=%0d, expected ctl=%h instret=%0d",
                     observe(), instret, e.ctl, e.icnt);
         else n_pass++;
         @(posedge clk); #1;
      end
      reset = 1'b1;
   endtask

   task automatic test_fetch_alu();
      sb_t e;
      int  k = 0;
      push_alu(I_ADDI,   1'b0, 4'b0000);
      push_alu(I_ADDI30, 1'b0, 4'b0000);
      push_alu(I_SUB,    1'b1, 4'b0001);
      push_alu(I_SRA,    1'b1, 4'b1000);
      push_alu(I_SRAI,   1'b0, 4'b1000);
      push_alu(I_SLTIU,  1'b0, 4'b1001);
      push_alu(I_AND,    1'b1, 4'b0010);
      push_alu(I_SLT,    1'b1, 4'b0101);
      push_alu(I_XORI,   1'b0, 4'b0100);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         Instr = e.ir; mem_ready = e.rdy; Zero = e.z;
         @(negedge clk);
         n_checks++;
         if ({observe(), instret} !== {e.ctl, e.icnt})
            $display("FAIL fetch_alu cyc%0d: got ctl=%h instret=%0d, expected ctl=%h instret=%0d",
                     k, observe(), instret, e.ctl, e.icnt);
         else n_pass++;
         k++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load();
      sb_t e;
      int  k = 0;
      // Each access answers on its second cycle; retire shows up in cycle 8
      push(I_LW, 1'b0, 1'b0, c_fetch(1'b0));
      push(I_LW, 1'b1, 1'b0, c_fetch(1'b1));
      push(I_LW, 1'b0, 1'b0, c_decode());
      push(I_LW, 1'b0, 1'b0, c_memadr(1'b0));
      push(I_LW, 1'b0, 1'b0, c_mem(1'b0));
      push(I_LW, 1'b1, 1'b0, c_mem(1'b0));
      push(I_LW, 1'b0, 1'b0, c_memwb());
      exp_instret++;
      push(I_LW, 1'b0, 1'b0, c_fetch(1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         Instr = e.ir; mem_ready = e.rdy; Zero = e.z;
         @(negedge clk);
         n_checks++;
         if ({observe(), instret} !== {e.ctl, e.icnt})
            $display("FAIL load cyc%0d: got ctl=%h instret=%0d, expected ctl=%h instret=%0d",
                     k, observe(), instret, e.ctl, e.icnt);
         else n_pass++;
         k++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store_back_to_back();
      sb_t e;
      int  k = 0;
      push(I_SW, 1'b1, 1'b0, c_fetch(1'b1));
      push(I_SW, 1'b0, 1'b0, c_decode());
      push(I_SW, 1'b0, 1'b0, c_memadr(1'b1));
      for (int i = 0; i < 4; i++) push(I_SW, 1'b0, 1'b1, c_mem(1'b1));
      push(I_SW, 1'b1, 1'b0, c_mem(1'b1));
      exp_instret++;
      push_alu(I_SUB, 1'b1, 4'b0001);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         Instr = e.ir; mem_ready = e.rdy; Zero = e.z;
         @(negedge clk);
         n_checks++;
         if ({observe(), instret} !== {e.ctl, e.icnt})
            $display("FAIL store cyc%0d: got ctl=%h instret=%0d, expected ctl=%h instret=%0d",
                     k, observe(), instret, e.ctl, e.icnt);
         else n_pass++;
         k++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_jal();
      sb_t         e;
      int          k = 0;
      logic [31:0] br [4] = '{I_BEQ, I_BEQ, I_BNE, I_BNE};
      logic        zf [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic        tk [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         push(br[i], 1'b1, 1'b0, c_fetch(1'b1));
         push(br[i], 1'b0, 1'b0, c_decode());
         push(br[i], 1'b0, zf[i], c_branch(tk[i]));
         exp_instret++;
      end
      push(I_JAL, 1'b1, 1'b0, c_fetch(1'b1));
      push(I_JAL, 1'b0, 1'b0, c_decode());
      push(I_JAL, 1'b0, 1'b0, c_jal());
      push(I_JAL, 1'b0, 1'b0, c_aluwb());
      exp_instret++;
      push(I_JAL, 1'b0, 1'b0, c_fetch(1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         Instr = e.ir; mem_ready = e.rdy; Zero = e.z;
         @(negedge clk);
         n_checks++;
         if ({observe(), instret} !== {e.ctl, e.icnt})
            $display("FAIL branch_jal cyc%0d: got ctl=%h instret=%0d, expected ctl=%h instret=%0d",
                     k, observe(), instret, e.ctl, e.icnt);
         else n_pass++;
         k++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      sb_t e;
      int  k = 0;
      push(I_OPBAD, 1'b1, 1'b0, c_fetch(1'b1));
      push(I_OPBAD, 1'b0, 1'b0, c_decode());
      for (int i = 0; i < 20; i++)
         push(I_OPBAD, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c_illegal());
      while (sb.size() > 0) begin
         e = sb.pop_front();
         Instr = e.ir; mem_ready = e.rdy; Zero = e.z;
         @(negedge clk);
         n_checks++;
         if ({observe(), instret} !== {e.ctl, e.icnt})
            $display("FAIL illegal_op cyc%0d: got ctl=%h instret=%0d, expected ctl=%h instret=%0d",
                     k, observe(), instret, e.ctl, e.icnt);
         else n_pass++;
         k++;
         @(posedge clk); #1;
      end
      reset = 1'b0; @(posedge clk); #1 reset = 1'b1;
      exp_instret = '0;
      k = 0;
      push(I_RBAD, 1'b1, 1'b0, c_fetch(1'b1));
      push(I_RBAD, 1'b0, 1'b0, c_decode());
      push(I_RBAD, 1'b0, 1'b0, c_exec(1'b1, 4'b0110));
      push(I_RBAD, 1'b1, 1'b0, c_illegal());
      push(I_RBAD, 1'b1, 1'b0, c_illegal());
      while (sb.size() > 0) begin
         e = sb.pop_front();
         Instr = e.ir; mem_ready = e.rdy; Zero = e.z;
         @(negedge clk);
         n_checks++;
         if ({observe(), instret} !== {e.ctl, e.icnt})
            $display("FAIL illegal_funct cyc%0d: got ctl=%h instret=%0d, expected ctl=%h instret=%0d",
                     k, observe(), instret, e.ctl, e.icnt);
         else n_pass++;
         k++;
         @(posedge clk); #1;
      end
      reset = 1'b0; @(posedge clk); #1 reset = 1'b1;
      k = 0;
      push(I_BBAD, 1'b1, 1'b0, c_fetch(1'b1));
      push(I_BBAD, 1'b0, 1'b0, c_decode());
      push(I_BBAD, 1'b0, 1'b0, c_branch(1'b0));
      push(I_BBAD, 1'b1, 1'b1, c_illegal());
      while (sb.size() > 0) begin
         e = sb.pop_front();
         Instr = e.ir; mem_ready = e.rdy; Zero = e.z;
         @(negedge clk);
         n_checks++;
         if ({observe(), instret} !== {e.ctl, e.icnt})
            $display("FAIL illegal_branch cyc%0d: got ctl=%h instret=%0d, expected ctl=%h instret=%0d",
                     k, observe(), instret, e.ctl, e.icnt);
         else n_pass++;
         k++;
         @(posedge clk); #1;
      end
      reset = 1'b0; @(posedge clk); #1 reset = 1'b1;
   endtask

   task automatic test_reset_mid_store();
      sb_t e;
      int  k = 0;
      push_alu(I_ADDI, 1'b0, 4'b0000);
      push(I_SW, 1'b1, 1'b0, c_fetch(1'b1));
      push(I_SW, 1'b0, 1'b0, c_decode());
      push(I_SW, 1'b0, 1'b0, c_memadr(1'b1));
      push(I_SW, 1'b0, 1'b0, c_mem(1'b1));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         Instr = e.ir; mem_ready = e.rdy; Zero = e.z;
         @(negedge clk);
         n_checks++;
         if ({observe(), instret} !== {e.ctl, e.icnt})
            $display("FAIL reset_store cyc%0d: got ctl=%h instret=%0d, expected ctl=%h instret=%0d",
                     k, observe(), instret, e.ctl, e.icnt);
         else n_pass++;
         k++;
         @(posedge clk); #1;
      end
      // Still in MEMWRITE waiting; pull reset mid-cycle with mem_ready high
      mem_ready = 1'b1;
      #2 reset = 1'b0;
      exp_instret = '0;
      #1;
      n_checks++;
      if ({observe(), instret} !== {ctl_t'('0), exp_instret})
         $display("FAIL reset_store async: got ctl=%h instret=%0d, expected ctl=0 instret=0",
                  observe(), instret);
      else n_pass++;
      @(posedge clk); #1 reset = 1'b1;
      k = 0;
      push(I_ADDI, 1'b0, 1'b0, c_fetch(1'b0));
      push_alu(I_ADDI, 1'b0, 4'b0000);
      push(I_ADDI, 1'b0, 1'b0, c_fetch(1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         Instr = e.ir; mem_ready = e.rdy; Zero = e.z;
         @(negedge clk);
         n_checks++;
         if ({observe(), instret} !== {e.ctl, e.icnt})
            $display("FAIL reset_restart cyc%0d: got ctl=%h instret=%0d, expected ctl=%h instret=%0d",
                     k, observe(), instret, e.ctl, e.icnt);
         else n_pass++;
         k++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_fetch_alu();
      test_load();
      test_store_back_to_back();
      test_branch_jal();
      test_illegal();
      test_reset_mid_store();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
